// File: rtl/radial_zone_cfg_pkg.sv
// Shared field encodings, global register addresses and reset values for the
// radial zone configuration block.
package radial_zone_cfg_pkg;

  typedef enum logic [2:0] {
    FLD_C      = 3'd0,
    FLD_Z      = 3'd1,
    FLD_ZMIN   = 3'd2,
    FLD_RADIUS = 3'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FORCE = 2'd2
  } cmt_state_e;

  localparam logic [7:0] ADDR_COL_CENTER = 8'h80;
  localparam logic [7:0] ADDR_ROW_CENTER = 8'h81;
  localparam logic [7:0] ADDR_CTRL       = 8'h82;
  localparam logic [7:0] ADDR_ERR_CLR    = 8'h83;

  localparam logic [15:0] Z_RST    = 16'h7BFF;
  localparam logic [15:0] C_RST    = 16'h0000;
  localparam logic [15:0] ZMIN_RST = 16'h0000;

  localparam int RADIUS_MAX = 511;

endpackage

// File: rtl/radial_zone_cfg_bank.sv
// One zone's shadow and active parameter registers; shadow loads per field,
// active takes the whole shadow on commit.
module radial_zone_cfg_bank
  import radial_zone_cfg_pkg::*;
#(
  parameter int RW = 18
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_c,
  input  logic          we_z,
  input  logic          we_zmin,
  input  logic          we_r,
  input  logic [15:0]   data,
  input  logic [RW-1:0] r_sq,
  input  logic          commit,
  output logic [15:0]   c,
  output logic [15:0]   z,
  output logic [15:0]   z_min,
  output logic [RW-1:0] r_squared
);

  logic [15:0]   sh_c, sh_z, sh_zmin;
  logic [RW-1:0] sh_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_c      <= C_RST;
      sh_z      <= Z_RST;
      sh_zmin   <= ZMIN_RST;
      sh_r      <= '0;
      c         <= C_RST;
      z         <= Z_RST;
      z_min     <= ZMIN_RST;
      r_squared <= '0;
    end else begin
      if (we_c)    sh_c    <= data;
      if (we_z)    sh_z    <= data;
      if (we_zmin) sh_zmin <= data;
      if (we_r)    sh_r    <= r_sq;
      if (commit) begin
        c         <= sh_c;
        z         <= sh_z;
        z_min     <= sh_zmin;
        r_squared <= sh_r;
      end
    end
  end

endmodule

// File: rtl/radial_zone_cfg.sv
// Register-write front end for the radial filter zone parameters: host writes
// fill a shadow bank that is copied to the outputs on frame sync or on force.
module radial_zone_cfg
  import radial_zone_cfg_pkg::*;
#(
  parameter int NO_ZONES = 1,
  parameter int RADIUS_W = 9
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 wr_valid_i,
  output logic                                 wr_ready_o,
  input  logic [7:0]                           wr_addr_i,
  input  logic [15:0]                          wr_data_i,
  input  logic                                 frame_sync_i,
  output logic [NO_ZONES-1:0][15:0]            c_o,
  output logic [NO_ZONES-1:0][15:0]            z_o,
  output logic [NO_ZONES-1:0][15:0]            z_min_o,
  output logic [NO_ZONES-1:0][2*RADIUS_W-1:0]  r_squared_o,
  output logic [15:0]                          col_center_o,
  output logic [15:0]                          row_center_o,
  output logic                                 commit_pending_o,
  output logic                                 commit_done_o,
  output logic                                 err_o
);

  localparam int RW = 2 * RADIUS_W;

  cmt_state_e          state, state_nxt;
  logic                is_zone, bad, accept, good_wr, arm, force_c, commit;
  logic [RADIUS_W-1:0] rad_sat;
  logic [RW-1:0]       rad_sq;
  logic [15:0]         col_sh, row_sh;

  always_comb begin
    is_zone = !wr_addr_i[7];
    if (is_zone)
      bad = (int'(wr_addr_i[6:3]) >= NO_ZONES) || (wr_addr_i[2:0] > FLD_RADIUS);
    else
      bad = (wr_addr_i[7:2] != 6'b100000);
    accept  = wr_valid_i && wr_ready_o;
    good_wr = accept && !bad;
    arm     = good_wr && (wr_addr_i == ADDR_CTRL) && !wr_data_i[1] && wr_data_i[0];
    force_c = good_wr && (wr_addr_i == ADDR_CTRL) && wr_data_i[1];
    // Radius is clamped to the representable range, then squared unsigned.
    rad_sat = (wr_data_i > 16'(RADIUS_MAX)) ? RADIUS_W'(RADIUS_MAX)
                                            : wr_data_i[RADIUS_W-1:0];
    rad_sq  = RW'(rad_sat) * RW'(rad_sat);
  end

  for (genvar g = 0; g < NO_ZONES; g++) begin : g_zone
    logic hit;
    assign hit = good_wr && is_zone && (wr_addr_i[6:3] == 4'(g));
    radial_zone_cfg_bank #(.RW(RW)) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_c      (hit && (wr_addr_i[2:0] == FLD_C)),
      .we_z      (hit && (wr_addr_i[2:0] == FLD_Z)),
      .we_zmin   (hit && (wr_addr_i[2:0] == FLD_ZMIN)),
      .we_r      (hit && (wr_addr_i[2:0] == FLD_RADIUS)),
      .data      (wr_data_i),
      .r_sq      (rad_sq),
      .commit    (commit),
      .c         (c_o[g]),
      .z         (z_o[g]),
      .z_min     (z_min_o[g]),
      .r_squared (r_squared_o[g])
    );
  end

  // Commit sequencing: ARMED waits for frame sync, FORCE commits one edge later.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARMED: if (frame_sync_i) state_nxt = ST_IDLE;
      default:  state_nxt = arm ? ST_ARMED : (force_c ? ST_FORCE : ST_IDLE);
    endcase
  end

  always_comb begin
    commit           = ((state == ST_ARMED) && frame_sync_i) || (state == ST_FORCE);
    commit_pending_o = (state == ST_ARMED);
    wr_ready_o       = (state != ST_ARMED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_sh        <= '0;
      row_sh        <= '0;
      col_center_o  <= '0;
      row_center_o  <= '0;
      commit_done_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      commit_done_o <= commit;
      if (good_wr && wr_addr_i == ADDR_COL_CENTER) col_sh <= wr_data_i;
      if (good_wr && wr_addr_i == ADDR_ROW_CENTER) row_sh <= wr_data_i;
      if (commit) begin
        col_center_o <= col_sh;
        row_center_o <= row_sh;
      end
      if (accept && bad)                             err_o <= 1'b1;
      else if (good_wr && wr_addr_i == ADDR_ERR_CLR) err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_radial_zone_cfg.sv
// Directed plus randomized check of radial_zone_cfg (NO_ZONES=2) against a
// shadow/active register model kept in the bench.
module tb_radial_zone_cfg;
  localparam int NZ = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i, wr_valid_i, frame_sync_i;
  logic [7:0]           wr_addr_i;
  logic [15:0]          wr_data_i;
  logic                 wr_ready_o, commit_pending_o, commit_done_o, err_o;
  logic [NZ-1:0][15:0]  c_o, z_o, z_min_o;
  logic [NZ-1:0][17:0]  r_squared_o;
  logic [15:0]          col_center_o, row_center_o;

  radial_zone_cfg #(.NO_ZONES(NZ), .RADIUS_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .frame_sync_i(frame_sync_i),
    .c_o(c_o), .z_o(z_o), .z_min_o(z_min_o), .r_squared_o(r_squared_o),
    .col_center_o(col_center_o), .row_center_o(row_center_o),
    .commit_pending_o(commit_pending_o), .commit_done_o(commit_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  // Model: shadow (s_*) and active (a_*) banks.
  logic [15:0] s_c[NZ], s_z[NZ], s_zm[NZ], a_c[NZ], a_z[NZ], a_zm[NZ];
  logic [17:0] s_r[NZ], a_r[NZ];
  logic [15:0] s_col, s_row, a_col, a_row;
  bit          m_pending, m_err;

  function automatic logic [17:0] sq(input logic [15:0] d);
    int v;
    v = (d > 16'd511) ? 511 : int'(d);
    return 18'(v * v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) begin
      s_c[i] = 16'h0; s_z[i] = 16'h7BFF; s_zm[i] = 16'h0; s_r[i] = 18'h0;
      a_c[i] = 16'h0; a_z[i] = 16'h7BFF; a_zm[i] = 16'h0; a_r[i] = 18'h0;
    end
    s_col = 0; s_row = 0; a_col = 0; a_row = 0;
    m_pending = 0; m_err = 0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < NZ; i++) begin
      a_c[i] = s_c[i]; a_z[i] = s_z[i]; a_zm[i] = s_zm[i]; a_r[i] = s_r[i];
    end
    a_col = s_col; a_row = s_row;
    m_pending = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [15:0] d, output bit frc);
    int zn, f;
    frc = 0;
    if (!a[7]) begin
      zn = int'(a[6:3]);
      f  = int'(a[2:0]);
      if (zn >= NZ || f > 3) m_err = 1;
      else case (f)
        0: s_c[zn]  = d;
        1: s_z[zn]  = d;
        2: s_zm[zn] = d;
        default: s_r[zn] = sq(d);
      endcase
    end else begin
      case (a)
        8'h80: s_col = d;
        8'h81: s_row = d;
        8'h82: if (d[1]) frc = 1; else if (d[0]) m_pending = 1;
        8'h83: m_err = 0;
        default: m_err = 1;
      endcase
    end
  endtask

  task automatic check_all(input string tag, input bit exp_done);
    for (int i = 0; i < NZ; i++) begin
      check({tag, "_c"},    c_o[i],         a_c[i]);
      check({tag, "_z"},    z_o[i],         a_z[i]);
      check({tag, "_zmin"}, z_min_o[i],     a_zm[i]);
      check({tag, "_rsq"},  r_squared_o[i], a_r[i]);
    end
    check({tag, "_col"},     col_center_o,     a_col);
    check({tag, "_row"},     row_center_o,     a_row);
    check({tag, "_pending"}, commit_pending_o, m_pending);
    check({tag, "_ready"},   wr_ready_o,       !m_pending);
    check({tag, "_err"},     err_o,            m_err);
    check({tag, "_done"},    commit_done_o,    exp_done);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One write handshake; a force write continues one more edge to its commit.
  task automatic wr(input string tag, input logic [7:0] a, input logic [15:0] d, input bit fs);
    bit frc;
    int cyc;
    cyc = 0;
    wr_valid_i = 1; wr_addr_i = a; wr_data_i = d; frame_sync_i = fs;
    while (!wr_ready_o && cyc < 20) begin tick(); cyc++; end
    if (!wr_ready_o) check({tag, "_ready_timeout"}, wr_ready_o, 1);
    tick();
    wr_valid_i = 0; frame_sync_i = 0;
    model_write(a, d, frc);
    check_all(tag, 0);
    if (frc) begin
      tick();
      model_commit();
      check_all({tag, "_force"}, 1);
    end
  endtask

  task automatic frame(input string tag);
    bit exp_done;
    frame_sync_i = 1;
    tick();
    frame_sync_i = 0;
    exp_done = m_pending;
    if (m_pending) model_commit();
    check_all(tag, exp_done);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    int          op;

    rst_i = 1; wr_valid_i = 0; frame_sync_i = 0; wr_addr_i = 0; wr_data_i = 0;
    repeat (3) tick();
    rst_i = 0;
    model_reset();
    check_all("reset", 0);
    check("reset_z0", z_o[0], 16'h7BFF);

    // Basic arm then frame sync a few cycles later.
    wr("w_c0", 8'h00, 16'h3C00, 0);
    wr("w_z0", 8'h01, 16'h4800, 0);
    wr("w_r0", 8'h03, 16'd100, 0);
    wr("arm",  8'h82, 16'h0001, 0);
    idle("armed_wait", 4);
    frame("commit1");
    check("commit1_c0", c_o[0], 16'h3C00);
    check("commit1_z0", z_o[0], 16'h4800);
    check("commit1_r0", r_squared_o[0], 18'd10000);
    idle("after_commit1", 1);

    // Writes stall while a commit is armed.
    wr("arm2", 8'h82, 16'h0001, 0);
    wr_valid_i = 1; wr_addr_i = 8'h80; wr_data_i = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("blocked", 0);
    end
    frame_sync_i = 1;
    tick();
    frame_sync_i = 0;
    model_commit();
    check_all("blk_commit", 1);
    tick();
    wr_valid_i = 0;
    s_col = 16'h1234;
    check_all("blk_accept", 0);
    check("blk_col_old", col_center_o, 16'h0000);
    wr("blk_force", 8'h82, 16'h0002, 0);
    check("blk_col_new", col_center_o, 16'h1234);

    // Arm in the same cycle as frame sync: only the next pulse commits.
    wr("w_c1", 8'h08, 16'hBEEF, 0);
    wr("arm_fs", 8'h82, 16'h0001, 1);
    check("arm_fs_c1", c_o[1], 16'h0000);
    idle("arm_fs_wait", 2);
    frame("arm_fs_commit");

    // Saturated radius with force commit.
    wr("w_rsat", 8'h03, 16'h0300, 0);
    wr("force_sat", 8'h82, 16'h0002, 0);
    check("force_sat_r0", r_squared_o[0], 18'd261121);
    check("force_sat_pend", commit_pending_o, 1'b0);

    // Bad zone address sets err, clear write drops it.
    wr("bad_zone", 8'h18, 16'hFFFF, 0);
    check("bad_zone_err", err_o, 1'b1);
    wr("err_clr", 8'h83, 16'h0000, 0);
    check("err_clr_err", err_o, 1'b0);
    frame("fs_nopend");

    // Reset while armed drops the commit.
    wr("w_c0b", 8'h00, 16'hAAAA, 0);
    wr("arm3", 8'h82, 16'h0001, 0);
    rst_i = 1;
    tick();
    rst_i = 0;
    model_reset();
    check_all("rst_pend", 0);
    frame("rst_fs");

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: begin
          a = {1'b0, 4'($urandom_range(0, 3)), 3'($urandom_range(0, 5))};
          d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
          wr("rnd_zone", a, d, 1'($urandom_range(0, 1)));
        end
        4: wr("rnd_glob", 8'(8'h80 + $urandom_range(0, 1)), 16'($urandom), 0);
        5: wr("rnd_badg", 8'($urandom_range(8'h84, 8'hFF)), 16'($urandom), 0);
        6: wr("rnd_clr", 8'h83, 16'($urandom), 0);
        7: wr("rnd_force", 8'h82, {14'($urandom), 1'b1, 1'($urandom)}, 0);
        8: begin
          wr("rnd_arm", 8'h82, {14'($urandom), 2'b01}, 1'($urandom_range(0, 1)));
          idle("rnd_wait", $urandom_range(0, 3));
          frame("rnd_frame");
        end
        default: frame("rnd_fs_idle");
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
